// File: rtl/game_flow_controller.sv
// Top-level game-flow FSM: lives, level index, timed respawn/level-clear intermissions.
// Define PAUSE_EN to include the Paused state toggled by PAUSE_CODE presses.
module game_flow_controller #(
   parameter int              KEY_W        = 8,
   parameter int              NUM_LIVES    = 3,
   parameter int              NUM_LEVELS   = 4,
   parameter int              DELAY_CYCLES = 120,
   parameter logic [KEY_W-1:0] PAUSE_CODE  = 8'h29
) (
   input  logic                                                    Clk,
   input  logic                                                    Reset,
   input  logic [KEY_W-1:0]                                        keycode,
   input  logic                                                    playerDead,
   input  logic                                                    levelDone,
   output logic [2:0]                                              gameState,
   output logic [$clog2(NUM_LIVES+1)-1:0]                          lives,
   output logic [((NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1)-1:0]  level,
   output logic                                                    gameplayEn,
   output logic                                                    delayActive
);

   localparam int LIVES_W = $clog2(NUM_LIVES+1);
   localparam int LEVEL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
   localparam int TMR_W   = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
   localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
   localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS-1);
   localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
   localparam logic [TMR_W-1:0]   TMR_INIT   = TMR_W'(DELAY_CYCLES-1);
   localparam logic [TMR_W-1:0]   TMR_ONE    = TMR_W'(1);

   typedef enum logic [2:0] {
      S_START   = 3'd0,
      S_PLAY    = 3'd1,
      S_OVER    = 3'd2,
`ifdef PAUSE_EN
      S_PAUSED  = 3'd3,
`endif
      S_RESPAWN = 3'd4,
      S_CLEAR   = 3'd5,
      S_VICTORY = 3'd6
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [LIVES_W-1:0] r_lives, w_lives_nxt;
   logic [LEVEL_W-1:0] r_level, w_level_nxt;
   logic [TMR_W-1:0]   r_timer, w_timer_nxt;
   logic [KEY_W-1:0]   r_key_prev;
   logic               w_press;

   // keyPrev resets to all-ones so a key held through reset release is not a press
   assign w_press = (keycode != '0) && (r_key_prev == '0);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= S_START;
         r_lives    <= '0;
         r_level    <= '0;
         r_timer    <= '0;
         r_key_prev <= '1;
      end else begin
         r_state    <= w_state_nxt;
         r_lives    <= w_lives_nxt;
         r_level    <= w_level_nxt;
         r_timer    <= w_timer_nxt;
         r_key_prev <= keycode;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lives_nxt = r_lives;
      w_level_nxt = r_level;
      w_timer_nxt = r_timer;
      case (r_state)
         S_START, S_OVER, S_VICTORY: begin
            if (w_press) begin
               w_state_nxt = S_PLAY;
               w_lives_nxt = LIVES_INIT;
               w_level_nxt = '0;
            end
         end
         S_PLAY: begin
            if (playerDead) begin
               if (r_lives <= LIVES_ONE) begin
                  w_lives_nxt = '0;
                  w_state_nxt = S_OVER;
               end else begin
                  w_lives_nxt = r_lives - LIVES_ONE;
                  w_timer_nxt = TMR_INIT;
                  w_state_nxt = S_RESPAWN;
               end
            end else if (levelDone) begin
               if (r_level >= LEVEL_LAST) begin
                  w_state_nxt = S_VICTORY;
               end else begin
                  w_timer_nxt = TMR_INIT;
                  w_state_nxt = S_CLEAR;
               end
            end
`ifdef PAUSE_EN
            else if (w_press && (keycode == PAUSE_CODE)) begin
               w_state_nxt = S_PAUSED;
            end
`endif
         end
`ifdef PAUSE_EN
         S_PAUSED: begin
            if (w_press && (keycode == PAUSE_CODE)) begin
               w_state_nxt = S_PLAY;
            end
         end
`endif
         S_RESPAWN, S_CLEAR: begin
            if (r_timer == '0) begin
               w_state_nxt = S_PLAY;
               if ((r_state == S_CLEAR) && (r_level < LEVEL_LAST)) begin
                  w_level_nxt = r_level + LEVEL_ONE;
               end
            end else begin
               w_timer_nxt = r_timer - TMR_ONE;
            end
         end
         default: begin
            w_state_nxt = S_START;
         end
      endcase
   end

   assign gameState   = r_state;
   assign lives       = r_lives;
   assign level       = r_level;
   assign gameplayEn  = (r_state == S_PLAY);
   assign delayActive = (r_state == S_RESPAWN) || (r_state == S_CLEAR);

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller (default parameters); honours PAUSE_EN.
module tb_game_flow_controller;

   localparam int DLY = 120;
`ifdef PAUSE_EN
   localparam logic [2:0] ST_PSE = 3'd3;
`else
   localparam logic [2:0] ST_PSE = 3'd1;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] keycode;
   logic       playerDead;
   logic       levelDone;
   logic [2:0] gameState;
   logic [1:0] lives;
   logic [1:0] level;
   logic       gameplayEn;
   logic       delayActive;

   typedef struct {
      string      name;
      logic [2:0] st;
      logic [1:0] lv;
      logic [1:0] lev;
      logic       en;
      logic       dly;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   game_flow_controller dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .playerDead  (playerDead),
      .levelDone   (levelDone),
      .gameState   (gameState),
      .lives       (lives),
      .level       (level),
      .gameplayEn  (gameplayEn),
      .delayActive (delayActive)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [2:0] st, input logic [1:0] lv,
                      input logic [1:0] lev);
      exp_t e;
      e.name = name;
      e.st   = st;
      e.lv   = lv;
      e.lev  = lev;
      e.en   = (st == 3'd1);
      e.dly  = (st == 3'd4) || (st == 3'd5);
      q.push_back(e);
   endtask

   // Called right after the entry edge has been checked; covers the remaining cycles and the exit.
   task automatic intermission(input string name, input logic [2:0] st, input logic [1:0] lv,
                               input logic [1:0] lev_during, input logic [1:0] lev_after);
      repeat (DLY-1) tick();
      chk({name, "_last"}, st, lv, lev_during);
      tick();
      chk({name, "_exit"}, 3'd1, lv, lev_after);
   endtask

   always @(negedge Clk) begin : monitor
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (gameState !== e.st || lives !== e.lv || level !== e.lev ||
             gameplayEn !== e.en || delayActive !== e.dly) begin
            errors++;
            $display("FAIL %s: got state=%0d lives=%0d level=%0d en=%b dly=%b, expected state=%0d lives=%0d level=%0d en=%b dly=%b",
                     e.name, gameState, lives, level, gameplayEn, delayActive,
                     e.st, e.lv, e.lev, e.en, e.dly);
         end
      end
   end

   initial begin
      Reset      = 1'b1;
      keycode    = 8'h00;
      playerDead = 1'b0;
      levelDone  = 1'b0;
      repeat (3) tick();
      chk("reset", 3'd0, 2'd0, 2'd0);
      Reset = 1'b0;
      tick();
      chk("idle_start", 3'd0, 2'd0, 2'd0);

      keycode = 8'h1A;
      tick();
      keycode = 8'h00;
      chk("start_press", 3'd1, 2'd3, 2'd0);

      // three deaths
      playerDead = 1'b1;
      tick();
      playerDead = 1'b0;
      chk("death1", 3'd4, 2'd2, 2'd0);
      intermission("respawn1", 3'd4, 2'd2, 2'd0, 2'd0);
      playerDead = 1'b1;
      tick();
      playerDead = 1'b0;
      chk("death2", 3'd4, 2'd1, 2'd0);
      intermission("respawn2", 3'd4, 2'd1, 2'd0, 2'd0);
      playerDead = 1'b1;
      keycode    = 8'h1A;
      tick();
      playerDead = 1'b0;
      chk("death3", 3'd2, 2'd0, 2'd0);
      tick();
      chk("over_held_key", 3'd2, 2'd0, 2'd0);
      keycode = 8'h00;
      tick();
      chk("over_release", 3'd2, 2'd0, 2'd0);
      keycode = 8'h1A;
      tick();
      keycode = 8'h00;
      chk("over_restart", 3'd1, 2'd3, 2'd0);

      // level progression to victory
      for (int k = 0; k < 3; k++) begin
         levelDone = 1'b1;
         tick();
         levelDone = 1'b0;
         chk($sformatf("clear%0d", k), 3'd5, 2'd3, 2'(k));
         intermission($sformatf("clear%0d", k), 3'd5, 2'd3, 2'(k), 2'(k+1));
      end
      levelDone = 1'b1;
      tick();
      levelDone = 1'b0;
      chk("victory", 3'd6, 2'd3, 2'd3);
      tick();
      chk("victory_hold", 3'd6, 2'd3, 2'd3);
      keycode = 8'h1A;
      tick();
      keycode = 8'h00;
      chk("victory_restart", 3'd1, 2'd3, 2'd0);

      // death wins over levelDone
      levelDone = 1'b1;
      tick();
      levelDone = 1'b0;
      chk("clear_again", 3'd5, 2'd3, 2'd0);
      intermission("clear_again", 3'd5, 2'd3, 2'd0, 2'd1);
      playerDead = 1'b1;
      levelDone  = 1'b1;
      tick();
      playerDead = 1'b0;
      levelDone  = 1'b0;
      chk("dead_and_done", 3'd4, 2'd2, 2'd1);
      intermission("respawn_both", 3'd4, 2'd2, 2'd1, 2'd1);

      // pause key
      keycode = 8'h29;
      tick();
      chk("pause_press", ST_PSE, 2'd2, 2'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("pause_held%0d", i), ST_PSE, 2'd2, 2'd1);
      end
`ifdef PAUSE_EN
      playerDead = 1'b1;
      levelDone  = 1'b1;
      tick();
      playerDead = 1'b0;
      levelDone  = 1'b0;
      chk("pause_ignores", 3'd3, 2'd2, 2'd1);
`endif
      keycode = 8'h00;
      tick();
      keycode = 8'h29;
      tick();
      keycode = 8'h00;
      chk("pause_second", 3'd1, 2'd2, 2'd1);

      // async reset mid level-clear
      levelDone = 1'b1;
      tick();
      levelDone = 1'b0;
      chk("clear_before_rst", 3'd5, 2'd2, 2'd1);
      repeat (10) tick();
      Reset = 1'b1;
      #1;
      chk("async_reset", 3'd0, 2'd0, 2'd0);

      // key held through reset release
      keycode = 8'h1A;
      tick();
      Reset = 1'b0;
      tick();
      chk("held_through_reset", 3'd0, 2'd0, 2'd0);
      tick();
      chk("held_after_reset", 3'd0, 2'd0, 2'd0);
      keycode = 8'h00;
      tick();
      chk("held_released", 3'd0, 2'd0, 2'd0);
      keycode = 8'h1A;
      tick();
      keycode = 8'h00;
      chk("fresh_press", 3'd1, 2'd3, 2'd0);

      repeat (2) @(negedge Clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
